// File: rtl/addr_map_pkg.sv
// Shared address-map constants and the default-slave state type for the
// data-side AHB-Lite decoder.
package addr_map_pkg;

  // Number of top address bits that form the region index.
  localparam int REGION_BITS     = 4;
  // Largest number of data-side slaves the region index can address.
  localparam int DATA_SLAVE_MAX  = 15;
  // Region value that selects slave 0; region 0 is instruction space.
  localparam int FIRST_SLAVE_HIT = 1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers transfers to unmapped regions with the two-cycle
// AHB ERROR response and answers IDLE/BUSY with a zero-wait OKAY.
module ahb_default_slave
  import addr_map_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic accept_i,   // miss NONSEQ/SEQ accepted this cycle
  output logic hready_o,
  output logic hresp_o
);

  ds_state_e state_q;
  ds_state_e state_d;

  // State register; synchronous reset aborts any response in progress.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of block ordering.
    if (!rst_ni) state_q <= DS_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic for the two-cycle ERROR response.
  always_comb begin
    // NOTE: a default assignment before the case keeps this block free of
    // inferred latches on any path that does not assign state_d.
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (accept_i) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = accept_i ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  // Response outputs decoded from the current state.
  always_comb begin
    hready_o = 1'b1;
    hresp_o  = 1'b0;
    case (state_q)
      DS_ERR1: begin hready_o = 1'b0; hresp_o = 1'b1; end
      DS_ERR2: begin hready_o = 1'b1; hresp_o = 1'b1; end
      default: begin hready_o = 1'b1; hresp_o = 1'b0; end
    endcase
  end

endmodule

// File: rtl/ahb_data_decoder.sv
// Data-side AHB-Lite decoder: region decode to HSEL, data-phase select
// register, response/read-data mux and sticky decode-error capture.
module ahb_data_decoder
  import addr_map_pkg::*;
#(
  parameter int NUM_SLAVES  = 15,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int REGION_BITS = addr_map_pkg::REGION_BITS
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [ADDR_WIDTH-1:0]            m_haddr_i,
  input  logic [1:0]                       m_htrans_i,
  input  logic                             m_hwrite_i,
  output logic                             m_hready_o,
  output logic                             m_hresp_o,
  output logic [DATA_WIDTH-1:0]            m_hrdata_o,
  output logic [NUM_SLAVES-1:0]            s_hsel_o,
  output logic                             s_hready_o,
  input  logic [NUM_SLAVES-1:0]            s_hreadyout_i,
  input  logic [NUM_SLAVES-1:0]            s_hresp_i,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_hrdata_i,
  output logic                             err_valid_o,
  output logic [ADDR_WIDTH-1:0]            err_addr_o,
  output logic                             err_write_o,
  input  logic                             err_clr_i
);

  // Select index NUM_SLAVES is the default slave.
  localparam int                SEL_W       = $clog2(NUM_SLAVES + 1);
  localparam logic [SEL_W-1:0]  DEFAULT_SEL = SEL_W'(NUM_SLAVES);

  logic [REGION_BITS-1:0] region;
  logic [SEL_W-1:0]       addr_sel;
  logic [SEL_W-1:0]       data_sel_q;
  logic                   miss;
  logic                   active_trans;
  logic                   accept_err;
  logic                   err_take;
  logic                   ds_hready;
  logic                   ds_hresp;

  assign region       = m_haddr_i[ADDR_WIDTH-1 -: REGION_BITS];
  // NONSEQ (2'b10) or SEQ (2'b11); IDLE and BUSY never start a response.
  assign active_trans = (m_htrans_i == 2'b10) || (m_htrans_i == 2'b11);

  // Address decode: one-hot HSEL on a hit, default slave on a miss.
  always_comb begin
    s_hsel_o = '0;
    addr_sel = DEFAULT_SEL;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (int'(region) == k + FIRST_SLAVE_HIT) begin
        s_hsel_o[k] = 1'b1;
        addr_sel    = SEL_W'(k);
      end
    end
  end

  assign miss       = (addr_sel == DEFAULT_SEL);
  assign accept_err = m_hready_o && active_trans && miss;

  // Data-phase target advances only when the current data phase completes.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)         data_sel_q <= DEFAULT_SEL;
    else if (m_hready_o) data_sel_q <= addr_sel;
  end

  ahb_default_slave u_default_slave (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .accept_i (accept_err),
    .hready_o (ds_hready),
    .hresp_o  (ds_hresp)
  );

  // Response mux from the data-phase target; default slave reads as zero.
  always_comb begin
    m_hready_o = ds_hready;
    m_hresp_o  = ds_hresp;
    m_hrdata_o = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (data_sel_q == SEL_W'(k)) begin
        m_hready_o = s_hreadyout_i[k];
        m_hresp_o  = s_hresp_i[k];
        m_hrdata_o = s_hrdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign s_hready_o = m_hready_o;

  // A clear in the same cycle as a new error lets the new error in.
  assign err_take = accept_err && (!err_valid_o || err_clr_i);

  // Sticky first-error capture of the offending address and direction.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_valid_o <= 1'b0;
      err_addr_o  <= '0;
      err_write_o <= 1'b0;
    end else if (err_take) begin
      err_valid_o <= 1'b1;
      err_addr_o  <= m_haddr_i;
      err_write_o <= m_hwrite_i;
    end else if (err_clr_i) begin
      err_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_data_decoder.sv
// Directed bench for ahb_data_decoder: a 15-slave instance for most
// scenarios and a 4-slave instance sharing the master bus for the
// out-of-range region case. Hit responses go through a scoreboard queue.
module tb_ahb_data_decoder;

  localparam int NS  = 15;
  localparam int NS4 = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [AW-1:0]     haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic              err_clr;

  logic              m_hready, m_hresp;
  logic [DW-1:0]     m_hrdata;
  logic [NS-1:0]     hsel;
  logic              s_hready;
  logic [NS-1:0]     hreadyout;
  logic [NS-1:0]     hresp_s;
  logic [NS*DW-1:0]  s_hrdata;
  logic              err_valid;
  logic [AW-1:0]     err_addr;
  logic              err_write;
  logic [DW-1:0]     slave_data [NS];

  logic              hready4, hresp4, s_hready4, err_valid4, err_write4;
  logic [DW-1:0]     hrdata4;
  logic [NS4-1:0]    hsel4;
  logic [AW-1:0]     err_addr4;

  always_comb begin
    for (int k = 0; k < NS; k++) s_hrdata[k*DW +: DW] = slave_data[k];
  end

  ahb_data_decoder #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REGION_BITS(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .m_haddr_i(haddr), .m_htrans_i(htrans), .m_hwrite_i(hwrite),
    .m_hready_o(m_hready), .m_hresp_o(m_hresp), .m_hrdata_o(m_hrdata),
    .s_hsel_o(hsel), .s_hready_o(s_hready), .s_hreadyout_i(hreadyout), .s_hresp_i(hresp_s),
    .s_hrdata_i(s_hrdata), .err_valid_o(err_valid), .err_addr_o(err_addr),
    .err_write_o(err_write), .err_clr_i(err_clr)
  );

  ahb_data_decoder #(.NUM_SLAVES(NS4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REGION_BITS(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .m_haddr_i(haddr), .m_htrans_i(htrans), .m_hwrite_i(hwrite),
    .m_hready_o(hready4), .m_hresp_o(hresp4), .m_hrdata_o(hrdata4),
    .s_hsel_o(hsel4), .s_hready_o(s_hready4), .s_hreadyout_i({NS4{1'b1}}), .s_hresp_i({NS4{1'b0}}),
    .s_hrdata_i({(NS4*DW){1'b0}}), .err_valid_o(err_valid4), .err_addr_o(err_addr4),
    .err_write_o(err_write4), .err_clr_i(err_clr)
  );

  typedef struct {
    string         tag;
    logic          hresp;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model of the address map for the 15-slave instance.
  function automatic exp_t model(input string tag, input logic [AW-1:0] a);
    exp_t e;
    int   r;
    r       = int'(a[AW-1 -: 4]);
    e.tag   = tag;
    e.hresp = 1'b1;
    e.rdata = '0;
    if (r >= 1 && r <= NS) begin
      e.hresp = 1'b0;
      e.rdata = slave_data[r-1];
    end
    return e;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [AW-1:0] a, input logic [1:0] t, input logic w);
    haddr  = a;
    htrans = t;
    hwrite = w;
  endtask

  // Issue an active transfer whose data phase is expected to be a slave hit.
  task automatic issue_hit(input string tag, input logic [AW-1:0] a, input logic w);
    drive(a, 2'b10, w);
    sb.push_back(model(tag, a));
  endtask

  // Compare the current completing data phase with the oldest expectation.
  task automatic check_resp();
    exp_t e;
    check("resp_hready", {63'd0, m_hready}, 64'd1);
    if (sb.size() == 0) begin
      check("sb_underflow", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_hresp"}, {63'd0, m_hresp}, {63'd0, e.hresp});
      check({e.tag, "_hrdata"}, {32'd0, m_hrdata}, {32'd0, e.rdata});
    end
  endtask

  task automatic check_ds(input string tag, input logic rdy, input logic rsp);
    check({tag, "_hready"}, {63'd0, m_hready}, {63'd0, rdy});
    check({tag, "_hresp"}, {63'd0, m_hresp}, {63'd0, rsp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    err_clr   = 1'b0;
    hreadyout = '1;
    hresp_s   = '0;
    for (int k = 0; k < NS; k++) slave_data[k] = 32'h1000_0000 + k * 32'h0101_0101;
    drive(32'h3000_0040, 2'b00, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hready", {63'd0, m_hready}, 64'd1);
    check("rst_hresp", {63'd0, m_hresp}, 64'd0);
    check("rst_hrdata", {32'd0, m_hrdata}, 64'd0);
    check("rst_err_valid", {63'd0, err_valid}, 64'd0);
    check("rst_err_addr", {32'd0, err_addr}, 64'd0);
    check("rst_err_write", {63'd0, err_write}, 64'd0);
    check("rst_hsel", {49'd0, hsel}, 64'h4);

    // Single NONSEQ read hit on slave 2
    next_cycle();
    rst_n = 1'b1;
    slave_data[2] = 32'hDEAD_BEEF;
    issue_hit("rd_s2", 32'h3000_0040, 1'b0);
    @(negedge clk);
    check("rd_s2_hsel", {49'd0, hsel}, 64'h4);
    check("rd_s2_s_hready", {63'd0, s_hready}, 64'd1);
    next_cycle();
    drive(32'h0000_0000, 2'b00, 1'b0);
    @(negedge clk);
    check("idle_hsel", {49'd0, hsel}, 64'h0);
    check_resp();

    // Back-to-back hits to different slaves: no wait states
    next_cycle();
    issue_hit("b2b_s0", 32'h1000_0000, 1'b0);
    next_cycle();
    issue_hit("b2b_s1", 32'h2000_0004, 1'b0);
    @(negedge clk);
    check_resp();
    next_cycle();
    issue_hit("b2b_s14", 32'hF000_0008, 1'b0);
    @(negedge clk);
    check_resp();
    next_cycle();
    drive(32'h0000_0000, 2'b00, 1'b0);
    @(negedge clk);
    check_resp();

    // NONSEQ write to instruction space: two-cycle ERROR plus capture
    next_cycle();
    drive(32'h0000_0100, 2'b10, 1'b1);
    next_cycle();
    drive(32'h0000_0000, 2'b00, 1'b0);
    @(negedge clk);
    check_ds("werr_c1", 1'b0, 1'b1);
    check("werr_valid", {63'd0, err_valid}, 64'd1);
    check("werr_addr", {32'd0, err_addr}, 64'h100);
    check("werr_write", {63'd0, err_write}, 64'd1);
    next_cycle();
    @(negedge clk);
    check_ds("werr_c2", 1'b1, 1'b1);
    next_cycle();
    err_clr = 1'b1;
    @(negedge clk);
    check_ds("werr_done", 1'b1, 1'b0);
    check("werr_dflt_rdata", {32'd0, m_hrdata}, 64'd0);
    check("clr_pending_valid", {63'd0, err_valid}, 64'd1);
    next_cycle();
    err_clr = 1'b0;
    @(negedge clk);
    check("clr_valid", {63'd0, err_valid}, 64'd0);

    // Region beyond NUM_SLAVES on the 4-slave instance
    next_cycle();
    issue_hit("r5_s4", 32'h5000_0000, 1'b0);
    @(negedge clk);
    check("r5_hsel4", {60'd0, hsel4}, 64'h0);
    check("r5_hsel", {49'd0, hsel}, 64'h10);
    next_cycle();
    drive(32'h0000_0000, 2'b00, 1'b0);
    @(negedge clk);
    check_resp();
    check("r5_c1_hready4", {63'd0, hready4}, 64'd0);
    check("r5_c1_hresp4", {63'd0, hresp4}, 64'd1);
    check("r5_err_valid4", {63'd0, err_valid4}, 64'd1);
    check("r5_err_addr4", {32'd0, err_addr4}, 64'h5000_0000);
    next_cycle();
    @(negedge clk);
    check("r5_c2_hready4", {63'd0, hready4}, 64'd1);
    check("r5_c2_hresp4", {63'd0, hresp4}, 64'd1);
    next_cycle();
    err_clr = 1'b1;
    drive(32'h5000_0000, 2'b00, 1'b0);
    @(negedge clk);
    check("r5_done_hresp4", {63'd0, hresp4}, 64'd0);
    next_cycle();
    err_clr = 1'b0;
    @(negedge clk);
    check("r5_idle_hready4", {63'd0, hready4}, 64'd1);
    check("r5_idle_hresp4", {63'd0, hresp4}, 64'd0);
    check("r5_cleared4", {63'd0, err_valid4}, 64'd0);
    next_cycle();
    drive(32'h0000_0000, 2'b00, 1'b0);
    @(negedge clk);
    check("r5_idle_nocap4", {63'd0, err_valid4}, 64'd0);
    check("r5_idle_ok_hresp4", {63'd0, hresp4}, 64'd0);

    // Slave 0 inserts three wait states while the next address is held
    next_cycle();
    issue_hit("ws_s0", 32'h1000_0000, 1'b0);
    next_cycle();
    issue_hit("ws_s1", 32'h2000_0000, 1'b0);
    hreadyout[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("ws%0d_hready", i), {63'd0, m_hready}, 64'd0);
      check($sformatf("ws%0d_sel_rdata", i), {32'd0, m_hrdata}, {32'd0, slave_data[0]});
      check($sformatf("ws%0d_hsel", i), {49'd0, hsel}, 64'h2);
      next_cycle();
    end
    hreadyout[0] = 1'b1;
    @(negedge clk);
    check_resp();
    next_cycle();
    drive(32'h0000_0000, 2'b00, 1'b0);
    @(negedge clk);
    check_resp();

    // Back-to-back misses, sticky capture, clear together with a third miss
    next_cycle();
    drive(32'h0000_0004, 2'b10, 1'b0);
    next_cycle();
    drive(32'h0000_0008, 2'b10, 1'b0);
    @(negedge clk);
    check_ds("bb_q1", 1'b0, 1'b1);
    check("bb_q1_addr", {32'd0, err_addr}, 64'h4);
    next_cycle();
    @(negedge clk);
    check_ds("bb_q2", 1'b1, 1'b1);
    next_cycle();
    drive(32'h0000_000C, 2'b10, 1'b1);
    @(negedge clk);
    check_ds("bb_q3", 1'b0, 1'b1);
    check("bb_q3_addr", {32'd0, err_addr}, 64'h4);
    next_cycle();
    err_clr = 1'b1;
    @(negedge clk);
    check_ds("bb_q4", 1'b1, 1'b1);
    check("bb_q4_addr", {32'd0, err_addr}, 64'h4);
    next_cycle();
    err_clr = 1'b0;
    drive(32'h0000_0000, 2'b00, 1'b0);
    @(negedge clk);
    check_ds("bb_q5", 1'b0, 1'b1);
    check("bb_q5_valid", {63'd0, err_valid}, 64'd1);
    check("bb_q5_addr", {32'd0, err_addr}, 64'hC);
    check("bb_q5_write", {63'd0, err_write}, 64'd1);
    next_cycle();
    @(negedge clk);
    check_ds("bb_q6", 1'b1, 1'b1);
    next_cycle();
    @(negedge clk);
    check_ds("bb_q7", 1'b1, 1'b0);

    // Synchronous reset during ERR1 aborts the response
    next_cycle();
    drive(32'h0000_0010, 2'b10, 1'b0);
    next_cycle();
    rst_n = 1'b0;
    drive(32'h0000_0000, 2'b00, 1'b0);
    @(negedge clk);
    check_ds("rerr_c1", 1'b0, 1'b1);
    next_cycle();
    @(negedge clk);
    check_ds("rerr_after", 1'b1, 1'b0);
    check("rerr_valid", {63'd0, err_valid}, 64'd0);
    check("rerr_addr", {32'd0, err_addr}, 64'd0);
    next_cycle();
    rst_n = 1'b1;

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
